// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues one word fetch at a time to instruction
// memory, buffers returned words with their PC in a small prefetch queue, and
// hands them to decode over a valid/ready handshake. Redirects flush the
// queue and squash an in-flight fetch; a HALT word stops further fetching.
module instr_fetch_unit #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
   localparam logic [3:0]        HALT_OPC   = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              squash_q, squash_d;
   logic              halted_q, halted_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Queue storage is data only; its contents are meaningless while count is 0.
   logic [DATA_W-1:0] word_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic xfer;
   logic push;
   logic pop;
   logic is_halt;

   // A fetch completes on ack while waiting; the word is kept only if it was
   // not squashed by an earlier redirect and no redirect arrives this cycle.
   assign xfer    = (state_q == ST_WAIT) && mem_ack;
   assign push    = xfer && !squash_q && !redirect;
   assign pop     = (count_q != '0) && instr_ready;
   assign is_halt = (mem_rdata[DATA_W-1 -: 4] == HALT_OPC);

   // Fetch FSM: next state, fetch PC, request address, squash and halt flags.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      squash_d   = squash_q;
      halted_d   = halted_q;
      case (state_q)
         ST_IDLE: begin
            // Count excludes nothing in flight here, so count < DEPTH
            // guarantees the returning word has a free slot.
            if (redirect) begin
               fetch_pc_d = redirect_pc;
            end else if (count_q < FULL_CNT) begin
               state_d    = ST_WAIT;
               req_addr_d = fetch_pc_q;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               squash_d = 1'b0;
               state_d  = ST_IDLE;
               if (redirect) begin
                  fetch_pc_d = redirect_pc;
               end else if (!squash_q) begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                  if (is_halt) begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end
               end
            end else if (redirect) begin
               // The request cannot be withdrawn: keep it on the bus and
               // throw its data away when it finally returns.
               squash_d   = 1'b1;
               fetch_pc_d = redirect_pc;
            end
         end
         ST_HALT: begin
            if (redirect) begin
               state_d    = ST_IDLE;
               halted_d   = 1'b0;
               fetch_pc_d = redirect_pc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_ADDR;
         req_addr_q <= RESET_ADDR;
         squash_q   <= 1'b0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         squash_q   <= squash_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Capture the returned word and the address it was fetched from.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr_q] <= mem_rdata;
         pc_q[wr_ptr_q]   <= req_addr_q;
      end
   end

   assign mem_req     = (state_q == ST_WAIT);
   assign mem_addr    = req_addr_q;
   assign instr_valid = (count_q != '0);
   assign instr_out   = word_q[rd_ptr_q];
   assign instr_pc    = pc_q[rd_ptr_q];
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory latency, random decode stalls and
// random redirects, checked by a scoreboard fed from a program-order model.
module tb_instr_fetch_unit;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4), .RESET_PC(0)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .instr_pc(instr_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
   );

   logic [DATA_W-1:0] mem [4096];
   assign mem_rdata = mem[mem_addr];

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] word;
   } ent_t;

   // Reference model: the instruction stream decode should see is simply
   // consecutive addresses from the last restart point, up to and including
   // the first HALT word.
   ent_t              exp_q[$];
   ent_t              mon_e;
   logic [ADDR_W-1:0] model_pc;
   bit                model_stop;

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   bit                flush_pend = 0;
   logic [ADDR_W-1:0] flush_pc;
   bit                req_seen = 0;
   int                wait_cnt = 0;
   int                ack_lo = 0;
   int                ack_hi = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void gen(input int n);
      for (int k = 0; k < n && !model_stop; k++) begin
         exp_q.push_back({model_pc, mem[model_pc]});
         if (mem[model_pc][31:28] == 4'h8) model_stop = 1;
         model_pc = model_pc + 12'd1;
      end
   endfunction

   function automatic void model_restart(input logic [ADDR_W-1:0] pc);
      exp_q.delete();
      model_pc   = pc;
      model_stop = 0;
      gen(8);
   endfunction

   // Monitor: every accepted instruction must be the next one in program order.
   always @(negedge clk) begin
      if (reset_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) gen(8);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc 0x%0h, none expected", instr_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(mon_e.pc));
            chk("instr_out", instr_out, mon_e.word);
            pops++;
         end
      end
   end

   // One clock: apply a pending model flush for a redirect taken at this edge,
   // drop the redirect pulse, then drive the memory acknowledge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (flush_pend) begin
         model_restart(flush_pc);
         flush_pend = 0;
      end
      redirect = 1'b0;
      if (mem_req) begin
         if (!req_seen) begin
            req_seen = 1;
            wait_cnt = $urandom_range(ack_hi, ack_lo);
         end
         if (wait_cnt == 0) begin
            mem_ack  = 1'b1;
            req_seen = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt--;
         end
      end else begin
         mem_ack = 1'b0;
      end
   endtask

   task automatic do_redirect(input logic [ADDR_W-1:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      flush_pend  = 1;
      flush_pc    = pc;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      int reqs;
      int p0;

      for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
      reset_n     = 1'b0;
      mem_ack     = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      model_restart(12'h000);
      repeat (3) tick();

      // Reset state
      chk("reset_mem_req", 32'(mem_req), 0);
      chk("reset_instr_valid", 32'(instr_valid), 0);
      chk("reset_halted", 32'(halted), 0);
      reset_n = 1'b1;

      // Decode stalled: queue fills to four, then fetching pauses
      ack_lo = 1; ack_hi = 1;
      repeat (30) tick();
      chk("full_instr_valid", 32'(instr_valid), 1);
      chk("full_mem_req", 32'(mem_req), 0);
      chk("full_head_pc", 32'(instr_pc), 0);
      instr_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mem_req) found = 1;
      end
      chk("resume_found", 32'(found), 1);
      chk("resume_addr", 32'(mem_addr), 32'h4);

      // Redirect while the fetch of pc 5 is outstanding
      ack_lo = 3; ack_hi = 3;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (mem_req && mem_addr == 12'd5 && !mem_ack) found = 1;
      end
      chk("pc5_req_found", 32'(found), 1);
      do_redirect(12'h020);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("squash_req_held", 32'(mem_req), 1);
         chk("squash_addr_held", 32'(mem_addr), 32'h5);
         if (mem_ack) break;
      end
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (instr_valid) found = 1;
      end
      chk("redirect_first_pc", 32'(instr_pc), 32'h020);

      // HALT word at pc 3
      ack_lo = 0; ack_hi = 2;
      mem[3] = 32'h8000_0000;
      tick();
      do_redirect(12'h000);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (halted) found = 1;
      end
      chk("halt_reached", 32'(found), 1);
      reqs = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_req) reqs++;
      end
      chk("halt_no_req", 32'(reqs), 0);
      chk("halt_still_halted", 32'(halted), 1);
      chk("halt_drained", 32'(instr_valid), 0);
      do_redirect(12'h000);
      tick();
      chk("halt_released", 32'(halted), 0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (halted) found = 1;
      end
      chk("halt_again", 32'(found), 1);
      mem[3] = 32'h0000_0003;

      // Address wrap from 0xFFE
      do_redirect(12'hFFE);
      p0 = pops;
      repeat (40) tick();
      chk("wrap_progress", 32'((pops - p0) >= 3), 1);

      // Random traffic: stalls, latency, redirects, a couple of HALT words
      mem[12'h050] = 32'h8000_0050;
      mem[12'h9AB] = 32'h8ABC_0000;
      ack_lo = 0; ack_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         tick();
         instr_ready = ($urandom_range(9, 0) < 7);
         if ($urandom_range(39, 0) == 0) begin
            if ($urandom_range(2, 0) == 0)
               do_redirect(12'hFFC + 12'($urandom_range(3, 0)));
            else
               do_redirect(12'($urandom_range(4095, 0)));
         end
      end

      // Asynchronous reset with a request outstanding and two words queued
      instr_ready = 1'b0;
      do_redirect(12'h000);
      ack_lo = 0; ack_hi = 0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (mem_req && mem_addr == 12'd2) found = 1;
         if (mem_req && mem_addr == 12'd1) begin
            ack_lo = 6; ack_hi = 6;
         end
      end
      chk("areset_setup", 32'(found && instr_valid && !mem_ack), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_mem_req", 32'(mem_req), 0);
      chk("areset_instr_valid", 32'(instr_valid), 0);
      chk("areset_halted", 32'(halted), 0);
      req_seen = 0;
      mem_ack  = 1'b0;
      model_restart(12'h000);
      ack_lo = 1; ack_hi = 1;
      repeat (2) tick();
      reset_n     = 1'b1;
      instr_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mem_req) found = 1;
      end
      chk("areset_first_req", 32'(found), 1);
      chk("areset_first_addr", 32'(mem_addr), 32'h0);
      repeat (20) tick();

      chk("liveness", 32'(pops >= 100), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
